// File: rtl/zbus_arbiter.sv
// rtl/zbus_arbiter.sv - round-robin zbus arbiter, MN sources to one shared sink with per-grant burst limit
//
// Parameters:
//   BW  - payload width
//   MN  - number of requesting sources (>= 2)
//   MNL - width of the grant index
//   BL  - maximum number of transfers per grant (>= 1)
// Ports:
//   z_clk  - clock, rising-edge active
//   z_rst  - synchronous active-high reset
//   s_vld  - per-source transfer valid            [MN]
//   s_bus  - per-source payload, source i at [i*BW +: BW]
//   s_ack  - per-source transfer acknowledge      [MN]
//   m_vld  - shared-sink transfer valid
//   m_bus  - shared-sink payload                  [BW]
//   m_ack  - shared-sink transfer acknowledge
//   m_sel  - current owner in BUSY, last released owner in IDLE
//   m_own  - high while a grant is held
module zbus_arbiter #(
    parameter int BW  = 8,
    parameter int MN  = 4,
    parameter int MNL = $clog2(MN),
    parameter int BL  = 4
) (
    input  logic             z_clk,
    input  logic             z_rst,
    input  logic [MN-1:0]    s_vld,
    input  logic [MN*BW-1:0] s_bus,
    output logic [MN-1:0]    s_ack,
    output logic             m_vld,
    output logic [BW-1:0]    m_bus,
    input  logic             m_ack,
    output logic [MNL-1:0]   m_sel,
    output logic             m_own
);

    localparam int CW = $clog2(BL) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [MNL-1:0] gnt, gnt_nxt;
    logic [MNL-1:0] lst, lst_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [MNL-1:0] win;
    logic           win_vld;
    logic [MNL-1:0] idx;
    logic           busy;
    logic           own_vld;
    logic           xfer;

    // Round-robin pick: first requester strictly after the last released owner,
    // wrapping around, so lst itself is considered last.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 1; k <= MN; k++) begin
            idx = MNL'((int'(lst) + k) % MN);
            if (!win_vld && s_vld[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    // Reset masks the datapath combinationally so a pending transfer is never
    // acknowledged in the reset cycle.
    assign busy    = (state == BUSY) && !z_rst;
    assign own_vld = s_vld[gnt];
    assign xfer    = busy && own_vld && m_ack;

    always_comb begin
        s_ack = '0;
        m_vld = 1'b0;
        m_bus = '0;
        m_own = 1'b0;
        m_sel = '0;
        if (busy) begin
            m_vld      = own_vld;
            m_bus      = s_bus[int'(gnt)*BW +: BW];
            s_ack[gnt] = m_ack;
            m_own      = 1'b1;
            m_sel      = gnt;
        end else if (!z_rst) begin
            m_sel = lst;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        lst_nxt   = lst;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = BUSY;
                    gnt_nxt   = win;
                end
            end
            BUSY: begin
                // Owner dropping vld, or the last transfer of the burst, ends the
                // grant; the IDLE state that follows guarantees a gap cycle.
                if (!own_vld || (xfer && cnt == CW'(BL - 1))) begin
                    state_nxt = IDLE;
                    lst_nxt   = gnt;
                    cnt_nxt   = '0;
                end else if (xfer) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge z_clk) begin
        if (z_rst) begin
            state <= IDLE;
            gnt   <= '0;
            lst   <= MNL'(MN - 1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            lst   <= lst_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: doc/zbus_arbiter.md
ZBUS_ARBITER -- requirements
Module: zbus_arbiter

Interface
REQ-001 SHALL have parameter BW, default 8, meaning the width of the grouped zbus payload.
REQ-002 SHALL have parameter MN, default 4, meaning the number of requesting zbus sources (MN >= 2).
REQ-003 SHALL have parameter MNL, default $clog2(MN), meaning the width of the grant index.
REQ-004 SHALL have parameter BL, default 4, meaning the maximum number of transfers per grant (BL >= 1).
REQ-005 SHALL have port z_clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-006 SHALL have port z_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port s_vld, input, MN bits: per-source transfer valid.
REQ-008 SHALL have port s_bus, input, MN*BW bits: per-source payload, source i at bits [i*BW +: BW].
REQ-009 SHALL have port s_ack, output, MN bits: per-source transfer acknowledge.
REQ-010 SHALL have port m_vld, output, 1 bit: shared-sink transfer valid.
REQ-011 SHALL have port m_bus, output, BW bits: shared-sink payload.
REQ-012 SHALL have port m_ack, input, 1 bit: shared-sink transfer acknowledge.
REQ-013 SHALL have port m_sel, output, MNL bits: index of the current grant owner.
REQ-014 SHALL have port m_own, output, 1 bit: high while a grant is held (state BUSY).

Function
REQ-015 SHALL define a transfer on a port as vld & ack high in the same cycle; sources keep vld high and bus stable until acknowledged.
REQ-016 SHALL implement two states: IDLE (no owner) and BUSY (owner = registered index gnt).
REQ-017 In IDLE: m_vld=0, s_ack=0, m_bus=0; if any s_vld bit is high, SHALL load gnt and enter BUSY at the next edge.
REQ-018 Arbitration SHALL be round-robin: the winner is the first set s_vld bit scanning from (lst+1) mod MN upward with wrap, where lst is the last released owner.
REQ-019 In BUSY: m_vld=s_vld[gnt], m_bus=s_bus[gnt], s_ack[gnt]=m_ack, all other s_ack bits 0; combinational, zero latency through the arbiter.
REQ-020 Grant latency SHALL be exactly one cycle: s_vld rising in IDLE at cycle N gives m_vld at cycle N+1 at the earliest.
REQ-021 A transfer counter cnt (width $clog2(BL)+1) SHALL increment on each m_vld & m_ack in BUSY.
REQ-022 In BUSY, release SHALL occur (next state IDLE, lst<=gnt, cnt<=0) when a transfer occurs with cnt==BL-1, or when s_vld[gnt]==0.
REQ-023 Release and the final transfer SHALL happen in the same cycle; at least one IDLE cycle SHALL always follow a release (no back-to-back grants).
REQ-024 With BL=1, every grant SHALL end after exactly one transfer.
REQ-025 Non-owner sources SHALL see s_ack=0 and be held, with no loss or duplication of transfers.
REQ-026 m_sel SHALL equal gnt in BUSY and lst in IDLE; m_own SHALL be 1 only in BUSY.
REQ-027 Changes of s_vld on non-owner bits during BUSY SHALL have no effect until the next IDLE arbitration.

Reset
REQ-028 While z_rst is high at a rising edge: state<=IDLE, gnt<=0, lst<=MN-1 (source 0 has first priority), cnt<=0.
REQ-029 While z_rst is high, m_vld and all s_ack bits SHALL be forced to 0 combinationally; m_own=0; m_sel and m_bus undefined-free (0).
REQ-030 Reset asserted mid-grant SHALL abort the grant without acknowledging the pending transfer; arbitration restarts from source 0.

Verification
REQ-031 Single source: s_vld=4'b0100, sink m_ack=1 always, 6 payloads queued -> m_sel=2, transfers 4 then 1 IDLE cycle then 2; payload order preserved.
REQ-032 All four sources requesting continuously, m_ack=1, BL=4 -> grant order 0,1,2,3,0; each grant exactly 4 transfers; one idle cycle between grants.
REQ-033 Owner 1 with sink delaying m_ack 3 cycles per transfer -> m_vld held, s_ack[1] pulses only with m_ack, other s_ack stay 0, no payload change during wait.
REQ-034 Owner 3 drops s_vld after 2 transfers (BL=4) -> release at that cycle, next grant goes to lowest requesting index after 3 with wrap (0 if requesting).
REQ-035 z_rst pulsed for 1 cycle while owner 2 is waiting on m_ack -> m_vld=0 and s_ack=0 during reset, no transfer counted, next grant goes to source 0 if requesting.
REQ-036 Sink checker (scoreboard per source) SHALL report zero mismatches and zero lost/duplicated transfers across all scenarios.
